// File: rtl/m_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: instruction encodings,
// func3 operation codes, FSM state encoding and operand signedness helpers.
package m_unit_pkg;

   localparam logic [6:0] OPCODE_OP    = 7'b0110011;
   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } func3_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } m_state_e;

   function automatic logic op1_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op2_is_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/m_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes/sign flags on the way in,
// two's-complement negation of the raw 64-bit result on the way out.
module m_unit_sign_fix
   import m_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        func3,
   input  logic [XLEN-1:0]   op1,
   input  logic [XLEN-1:0]   op2,
   output logic [XLEN-1:0]   mag1,
   output logic [XLEN-1:0]   mag2,
   output logic              sign1,
   output logic              sign2,
   input  logic [2*XLEN-1:0] raw,
   input  logic              negate,
   output logic [2*XLEN-1:0] fixed
);

   always_comb begin
      sign1 = op1_is_signed(func3) & op1[XLEN-1];
      sign2 = op2_is_signed(func3) & op2[XLEN-1];
      mag1  = sign1 ? (~op1 + 1'b1) : op1;
      mag2  = sign2 ? (~op2 + 1'b1) : op2;
      fixed = negate ? (~raw + 1'b1) : raw;
   end

endmodule

// File: rtl/m_unit.sv
// Iterative RV32M unit: 32-cycle shift-add multiply and restoring divide
// sharing one 64-bit accumulator; divide-by-zero and overflow finish in one cycle.
module m_unit
   import m_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output m_state_e        state_dbg
);

   m_state_e          state;
   logic [5:0]        cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb;
   func3_e            f3_q;
   logic [4:0]        rd_q;
   logic              sign1_q, sign2_q;

   logic [XLEN-1:0]   mag1, mag2;
   logic              sign1, sign2;
   logic [2*XLEN-1:0] fix_raw, fix_out;
   logic              fix_neg;
   logic [XLEN:0]     add_sum;
   logic [XLEN-1:0]   sub_diff;
   logic              sub_ge;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN-1:0]   res_final;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   special_res;

   m_unit_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .func3  (func3),
      .op1    (op1),
      .op2    (op2),
      .mag1   (mag1),
      .mag2   (mag2),
      .sign1  (sign1),
      .sign2  (sign2),
      .raw    (fix_raw),
      .negate (fix_neg),
      .fixed  (fix_out)
   );

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend} for divide.
   always_comb begin
      add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : {XLEN{1'b0}})};
      sub_ge   = acc[2*XLEN-1:XLEN-1] >= {1'b0, opb};
      sub_diff = acc[2*XLEN-2:XLEN-1] - opb;
      if (!f3_q[2])
         acc_step = {add_sum, acc[XLEN-1:1]};
      else if (sub_ge)
         acc_step = {sub_diff, acc[XLEN-2:0], 1'b1};
      else
         acc_step = {acc[2*XLEN-2:0], 1'b0};
   end

   always_comb begin
      fix_raw = acc_step;
      fix_neg = sign1_q ^ sign2_q;
      case (f3_q)
         F3_DIV, F3_DIVU: fix_raw = {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
         F3_REM, F3_REMU: begin
            fix_raw = {{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]};
            fix_neg = sign1_q;
         end
         default: fix_raw = acc_step;
      endcase
      res_final = (f3_q[2] || f3_q == F3_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
   end

   always_comb begin
      div_zero    = func3[2] && (op2 == {XLEN{1'b0}});
      div_ovf     = func3[2] && !func3[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (op2 == {XLEN{1'b1}});
      special_res = func3[1] ? (div_zero ? op1 : {XLEN{1'b0}})
                             : (div_zero ? {XLEN{1'b1}} : op1);
   end

   assign busy      = rst && (((state == ST_IDLE) && start && !kill) || (state == ST_CALC));
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         acc          <= '0;
         opb          <= '0;
         f3_q         <= F3_MUL;
         rd_q         <= '0;
         sign1_q      <= 1'b0;
         sign2_q      <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         rd_out       <= '0;
      end else begin
         result_valid <= 1'b0;
         if (kill) begin
            state <= ST_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               ST_IDLE: if (start) begin
                  f3_q    <= func3_e'(func3);
                  rd_q    <= rd_in;
                  sign1_q <= sign1;
                  sign2_q <= sign2;
                  cnt     <= '0;
                  if (div_zero || div_ovf) begin
                     result       <= special_res;
                     rd_out       <= rd_in;
                     result_valid <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     acc   <= {{XLEN{1'b0}}, (func3[2] ? mag1 : mag2)};
                     opb   <= func3[2] ? mag2 : mag1;
                     state <= ST_CALC;
                  end
               end
               ST_CALC: begin
                  acc <= acc_step;
                  if (cnt == 6'(ITER - 1)) begin
                     result       <= res_final;
                     rd_out       <= rd_q;
                     result_valid <= 1'b1;
                     cnt          <= '0;
                     state        <= ST_DONE;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_m_unit.sv
// Bench for m_unit: directed RV32M cases, randomized operations against an
// arithmetic reference model, kill/reset/held-start scenarios.
module tb_m_unit;
   import m_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  func3 = '0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, result_valid;
   logic [31:0] result;
   logic [4:0]  rd_out;
   m_state_e    state_dbg;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   m_unit #(.XLEN(32), .ITER(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .kill         (kill),
      .func3        (func3),
      .op1          (op1),
      .op2          (op2),
      .rd_in        (rd_in),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result),
      .rd_out       (rd_out),
      .state_dbg    (state_dbg)
   );

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h80000000) && (b == 32'hffffffff);
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hffffffff;
            if (ovf) return 32'h80000000;
            p = 64'(sa / sb); return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hffffffff;
            p = 64'(ua / ub); return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = 64'(sa % sb); return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = 64'(ua % ub); return p[31:0];
         end
      endcase
   endfunction

   function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0)) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hffffffff) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hffffffff;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 100));
         5: return 32'h7fffffff;
         default: return $urandom;
      endcase
   endfunction

   // One operation: accept, scramble inputs afterwards, check latency, busy profile, result, rd.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
      logic [31:0] exp;
      int lat, seen, busy_err;
      exp = model(f, a, b);
      lat = latency(f, a, b);
      @(negedge clk);
      start = 1'b1; func3 = f; op1 = a; op2 = b; rd_in = rd;
      #1;
      busy_err = (busy !== 1'b1) ? 1 : 0;
      seen = 0;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
         @(negedge clk);
         start = 1'b0; func3 = 3'($urandom); op1 = $urandom; op2 = $urandom; rd_in = 5'($urandom);
         #1;
         if (result_valid === 1'b1) seen = k;
         if (busy !== 1'(k < lat)) busy_err++;
      end
      vectors++;
      if (seen != lat) begin
         miscompares++;
         $display("FAIL latency f3=%0d a=%h b=%h: got %0d want %0d", f, a, b, seen, lat);
      end
      vectors++;
      if (result !== exp) begin
         miscompares++;
         $display("FAIL result f3=%0d a=%h b=%h: got %h want %h", f, a, b, result, exp);
      end
      vectors++;
      if (rd_out !== rd) begin
         miscompares++;
         $display("FAIL rd_out f3=%0d: got %0d want %0d", f, rd_out, rd);
      end
      vectors++;
      if (busy_err != 0) begin
         miscompares++;
         $display("FAIL busy_profile f3=%0d a=%h b=%h: got %0d bad cycles want 0", f, a, b, busy_err);
      end
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      int hits;
      hits = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk); #1;
         if (result_valid !== 1'b0 || busy !== 1'b0) hits++;
      end
      vectors++;
      if (hits != 0) begin
         miscompares++;
         $display("FAIL %s quiet: got %0d active cycles want 0", name, hits);
      end
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if ({busy, result_valid, result, rd_out} !== 39'b0 || state_dbg !== ST_IDLE) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b rv=%b res=%h rd=%0d st=%0d want all 0",
                  busy, result_valid, result, rd_out, state_dbg);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_idle: got busy=%b rv=%b want 0 0", busy, result_valid);
      end
   endtask

   task automatic test_directed();
      run_op(3'd0, 32'd7, 32'hfffffffd, 5'd3);
      run_op(3'd3, 32'hffffffff, 32'hffffffff, 5'd4);
      run_op(3'd1, 32'hffffffff, 32'hffffffff, 5'd5);
      run_op(3'd4, 32'hffffffec, 32'd3, 5'd6);
      run_op(3'd6, 32'hffffffec, 32'd3, 5'd7);
      run_op(3'd5, 32'h1234, 32'd0, 5'd8);
      run_op(3'd7, 32'h1234, 32'd0, 5'd9);
      run_op(3'd4, 32'h80000000, 32'hffffffff, 5'd10);
      run_op(3'd6, 32'h80000000, 32'hffffffff, 5'd11);
      run_op(3'd2, 32'hffffffff, 32'hffffffff, 5'd12);
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++)
         for (int n = 0; n < 6; n++)
            run_op(3'(f), pick(), pick(), 5'($urandom_range(1, 31)));
   endtask

   task automatic test_hold_result();
      logic [31:0] exp;
      exp = model(3'd0, 32'd1000, 32'd1000);
      run_op(3'd0, 32'd1000, 32'd1000, 5'd17);
      @(negedge clk); #1;
      vectors++;
      if (result_valid !== 1'b0 || result !== exp || rd_out !== 5'd17) begin
         miscompares++;
         $display("FAIL hold_after_done: got rv=%b res=%h rd=%0d want 0 %h 17",
                  result_valid, result, rd_out, exp);
      end
   endtask

   task automatic test_kill();
      @(negedge clk);
      start = 1'b1; func3 = 3'd4; op1 = 32'd1000; op2 = 32'd7; rd_in = 5'd2;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
         miscompares++;
         $display("FAIL kill_busy: got busy=%b st=%0d want 0 IDLE", busy, state_dbg);
      end
      expect_quiet("after_kill", 40);
      @(negedge clk);
      start = 1'b1; kill = 1'b1; func3 = 3'd0; op1 = 32'd5; op2 = 32'd5;
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL kill_priority_busy: got %b want 0", busy);
      end
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      expect_quiet("kill_priority", 40);
   endtask

   task automatic test_async_reset();
      run_op(3'd0, 32'd9, 32'd9, 5'd21);
      @(negedge clk);
      start = 1'b1; func3 = 3'd3; op1 = $urandom; op2 = $urandom; rd_in = 5'd22;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({busy, result_valid, result, rd_out} !== 39'b0 || state_dbg !== ST_IDLE) begin
         miscompares++;
         $display("FAIL async_reset: got busy=%b rv=%b res=%h rd=%0d st=%0d want all 0",
                  busy, result_valid, result, rd_out, state_dbg);
      end
      @(negedge clk);
      rst = 1'b1;
      expect_quiet("after_reset", 40);
      run_op(3'd7, 32'd100, 32'd7, 5'd23);
   endtask

   task automatic test_start_held();
      int seen, extra;
      logic [31:0] exp;
      exp = model(3'd5, 32'd99, 32'd4);
      @(negedge clk);
      start = 1'b1; func3 = 3'd5; op1 = 32'd99; op2 = 32'd4; rd_in = 5'd14;
      seen = 0;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
         @(negedge clk); #1;
         if (result_valid === 1'b1) seen = k;
      end
      vectors++;
      if (seen != 33 || result !== exp) begin
         miscompares++;
         $display("FAIL held_start_first: got lat=%0d res=%h want 33 %h", seen, result, exp);
      end
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (result_valid === 1'b1 || busy === 1'b1) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL held_start_second_op: got %0d active cycles want 0", extra);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold_result();
      test_kill();
      test_async_reset();
      test_start_held();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
